itr_event_merger: RTL and testbench

ITR_EVENT_MERGER -- requirements
Module: itr_event_merger

---
 rtl/itr_event_merger.sv | 113 +++++++++++
 tb/tb_itr_event_merger.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/itr_event_merger.sv
// Merges per-source raw events into pending flags and a rate-limited single-cycle
// interrupt pulse; every new pending source is reported exactly once.

module itr_src_cell #(
   parameter bit edge_det = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic evt,
   input  logic mask,
   input  logic clr,
   input  logic rpt_set,
   output logic pend,
   output logic rpt
);
   logic evt_d;
   logic detect;
   logic set;

   assign detect = edge_det ? (evt & ~evt_d) : evt;
   assign set    = detect & mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_d <= 1'b0;
         pend  <= 1'b0;
         rpt   <= 1'b0;
      end else begin
         evt_d <= evt;
         // set beats clear; rpt drops on any clear so a re-set source reports again
         pend  <= set | (pend & ~clr);
         rpt   <= clr ? 1'b0 : (rpt | (rpt_set & pend));
      end
   end
endmodule

module itr_event_merger #(
   parameter int                src_n     = 4,
   parameter logic [src_n-1:0]  edge_mode = {src_n{1'b1}},
   parameter int                min_gap   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [src_n-1:0] evt_in,
   input  logic             itr_en,
   input  logic [src_n-1:0] itr_mask,
   input  logic [src_n-1:0] pend_clr,
   output logic [src_n-1:0] pend_sts,
   output logic             itr_org
);
   localparam int             CW       = $clog2(min_gap) + 1;
   localparam logic [CW-1:0]  GAP_LAST = CW'(min_gap - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   gap_cnt, gap_cnt_nxt;
   logic [src_n-1:0] rpt;
   logic [src_n-1:0] new_pend;
   logic            fire;

   assign new_pend = pend_sts & ~rpt;
   assign fire     = (state == IDLE) && itr_en && (|new_pend);

   for (genvar i = 0; i < src_n; i++) begin : g_src
      itr_src_cell #(
         .edge_det (edge_mode[i])
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .evt     (evt_in[i]),
         .mask    (itr_mask[i]),
         .clr     (pend_clr[i]),
         .rpt_set (fire),
         .pend    (pend_sts[i]),
         .rpt     (rpt[i])
      );
   end

   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      case (state)
         IDLE: if (fire) state_nxt = FIRE;
         FIRE: begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gap_cnt <= '0;
         itr_org <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
         // high only for the cycle spent in FIRE
         itr_org <= fire;
      end
   end
endmodule

// File: tb/tb_itr_event_merger.sv
// Randomised plus directed checking of itr_event_merger against a timing-based
// reference model (pulse allowed only min_gap+2 edges after the previous one).

module tb_itr_event_merger;
   localparam int         N  = 4;
   localparam logic [3:0] EM = 4'b0111;
   localparam int         MG = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] evt_in, itr_mask, pend_clr, pend_sts;
   logic         itr_en, itr_org;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [N-1:0] m_pend, m_rpt, m_evd;
   logic         m_org;
   int           cyc, next_ok;

   itr_event_merger #(
      .src_n     (N),
      .edge_mode (EM),
      .min_gap   (MG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .evt_in   (evt_in),
      .itr_en   (itr_en),
      .itr_mask (itr_mask),
      .pend_clr (pend_clr),
      .pend_sts (pend_sts),
      .itr_org  (itr_org)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model: pending set/clear rules per source, and a pulse whenever unreported
   // pending exists, itr_en is high and the spacing window has elapsed.
   task automatic model_edge();
      logic [N-1:0] det, newp;
      logic         f;
      if (rst) begin
         m_pend = '0; m_rpt = '0; m_evd = '0; m_org = 1'b0;
         next_ok = 0;
      end else begin
         for (int i = 0; i < N; i++)
            det[i] = EM[i] ? (evt_in[i] & ~m_evd[i]) : evt_in[i];
         newp = m_pend & ~m_rpt;
         f = itr_en && (cyc >= next_ok) && (newp != 0);
         if (f) next_ok = cyc + MG + 2;
         m_org  = f;
         m_rpt  = (m_rpt | (f ? newp : '0)) & ~pend_clr;
         m_pend = (det & itr_mask) | (m_pend & ~pend_clr);
         m_evd  = evt_in;
      end
      cyc++;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("pend_sts", 32'(pend_sts), 32'(m_pend));
      chk("itr_org", 32'(itr_org), 32'(m_org));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      cyc = 0; next_ok = 0;
      m_pend = '0; m_rpt = '0; m_evd = '0; m_org = 1'b0;
      rst = 1'b1; evt_in = '0; itr_en = 1'b1; itr_mask = '0; pend_clr = '0;
      #2;
      run(2);
      chk("rst_pend", 32'(pend_sts), 32'h0);
      chk("rst_org", 32'(itr_org), 32'h0);
      rst = 1'b0;
      run(2);

      // single edge on source 0: pending next edge, pulse one edge later
      itr_mask = 4'b0001;
      evt_in[0] = 1'b1;
      step();
      chk("single_pend", 32'(pend_sts), 32'h1);
      chk("single_org0", 32'(itr_org), 32'h0);
      step();
      chk("single_org1", 32'(itr_org), 32'h1);
      step();
      chk("single_org_fall", 32'(itr_org), 32'h0);

      // second source during GAP merges into a later single pulse
      itr_mask = 4'b0011;
      step();
      evt_in[1] = 1'b1;
      step();
      chk("merge_pend", 32'(pend_sts), 32'h3);
      run(14);

      // clear/set collision on source 0
      evt_in[0] = 1'b0;
      step();
      evt_in[0] = 1'b1; pend_clr = 4'b0001;
      step();
      pend_clr = '0;
      chk("collide_pend", 32'(pend_sts), 32'h3);
      run(14);

      // gated by itr_en
      pend_clr = 4'b0011; step(); pend_clr = '0;
      itr_en = 1'b0; itr_mask = 4'b0100; evt_in[2] = 1'b1;
      run(14);
      chk("gate_org", 32'(itr_org), 32'h0);
      itr_en = 1'b1;
      run(3);

      // level source 3 held high, cleared after its first pulse
      itr_mask = 4'b1000; evt_in[3] = 1'b1;
      run(4);
      pend_clr = 4'b1000; step(); pend_clr = '0;
      run(14);
      evt_in[3] = 1'b0; pend_clr = 4'b1111; step(); pend_clr = '0;
      run(12);

      // reset in GAP with two pending sources, source 0 still high afterwards
      evt_in = '0; itr_mask = 4'b0011; step();
      evt_in = 4'b0011;
      run(4);
      rst = 1'b1; step(); rst = 1'b0;
      chk("gaprst_pend", 32'(pend_sts), 32'h0);
      chk("gaprst_org", 32'(itr_org), 32'h0);
      run(4);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) evt_in[i] = ~evt_in[i];
         itr_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : itr_mask | 4'($urandom);
         pend_clr = ($urandom_range(0, 4) == 0) ? 4'($urandom) : '0;
         itr_en   = ($urandom_range(0, 7) != 0);
         rst      = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
